// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
// Digit code width, blank pattern and parameter sanity helpers.
package seven_seg_pkg;

    localparam int DIGIT_W = 5;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A slot needs at least one lit cycle after the dead time.
    function automatic bit params_ok(
        input int div,
        input int blank,
        input int nd
    );
        return (div > blank + 1) && (blank >= 0)
            && (nd >= 2) && (nd <= 8);
    endfunction

endpackage

// File: rtl/binary_to_segment.sv
// 5-bit digit code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Codes 0-15 are hex glyphs, 16 is a dash, everything else is dark.
module binary_to_segment
    import seven_seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] bin,
    output logic [6:0]         seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_OFF;
        case (bin)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h03;
            5'd12:   seg = 7'h46;
            5'd13:   seg = 7'h21;
            5'd14:   seg = 7'h06;
            5'd15:   seg = 7'h0E;
            5'd16:   seg = 7'h3F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode N-digit scanner with dead time,
// frame-coherent shadowing, per-digit enable/dp and leading-zero blanking.
module seven_segment_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] big_bin,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lz_en,
    output logic [NUM_DIGITS-1:0]         AN,
    output logic [6:0]                    seven_out,
    output logic                          dp_n,
    output logic                          frame_tick
);

    localparam int PW = cnt_w(REFRESH_DIV);
    localparam int IW = cnt_w(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    if (!params_ok(REFRESH_DIV, BLANK_CYCLES, NUM_DIGITS)) begin : g_bad
        $error("seven_segment_scan: illegal parameter set");
    end

    logic [PW-1:0]                 presc;
    logic [IW-1:0]                 idx;
    logic [DIGIT_W*NUM_DIGITS-1:0] bin_sh;
    logic [NUM_DIGITS-1:0]         dp_sh;
    logic [NUM_DIGITS-1:0]         en_sh;
    logic                          lz_sh;

    logic                  slot_tick;
    logic                  wrap;
    logic                  in_blank;
    logic [NUM_DIGITS-1:0] supp;
    logic                  run;
    logic [DIGIT_W-1:0]    cur_code;
    logic                  cur_dp;
    logic                  cur_vis;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    assign slot_tick = (presc == PRE_LAST);
    assign wrap      = slot_tick && (idx == IDX_LAST);

    if (BLANK_CYCLES == 0) begin : g_no_dead
        assign in_blank = 1'b0;
    end else begin : g_dead
        assign in_blank = (presc < PW'(BLANK_CYCLES));
    end

    // Prescaler and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= slot_tick ? '0 : presc + 1'b1;
            if (slot_tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Shadow copy of the display inputs, refreshed only at frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sh <= '0;
            dp_sh  <= '0;
            en_sh  <= '0;
            lz_sh  <= 1'b0;
        end else if (wrap) begin
            bin_sh <= big_bin;
            dp_sh  <= dp_in;
            en_sh  <= digit_en;
            lz_sh  <= lz_en;
        end
    end

    // Leading-zero mask: a zero run from the top digit down, digit 0 exempt
    always_comb begin
        supp = '0;
        run  = lz_sh;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run     = run && (bin_sh[i*DIGIT_W +: DIGIT_W] == '0);
            supp[i] = run;
        end
    end

    // Select the shadow digit for the current scan slot
    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_vis  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code = bin_sh[i*DIGIT_W +: DIGIT_W];
                cur_dp   = dp_sh[i];
                cur_vis  = en_sh[i] && !supp[i];
            end
        end
    end

    binary_to_segment u_dec (
        .bin (cur_code),
        .seg (dec_seg)
    );

    // Next pin state: dark during dead time or for invisible digits
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (!in_blank && cur_vis) begin
            an_nxt  = ~(NUM_DIGITS'(1) << idx);
            seg_nxt = dec_seg;
            dp_nxt  = ~cur_dp;
        end
    end

    // Registered pins so anode and cathode move on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            AN         <= '1;
            seven_out  <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            AN         <= an_nxt;
            seven_out  <= seg_nxt;
            dp_n       <= dp_nxt;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: 4 digits, 8-cycle slots, with and
// without dead time, frame-level expectations from a vector table.
module tb_seven_segment_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] big_bin;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_en;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dpn_a, dpn_b;
    logic       ft_a, ft_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_segment_scan #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .big_bin    (big_bin),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_en      (lz_en),
        .AN         (an_a),
        .seven_out  (seg_a),
        .dp_n       (dpn_a),
        .frame_tick (ft_a)
    );

    seven_segment_scan #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .big_bin    (big_bin),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_en      (lz_en),
        .AN         (an_b),
        .seven_out  (seg_b),
        .dp_n       (dpn_b),
        .frame_tick (ft_b)
    );

    typedef struct packed {
        logic [19:0]     bin;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic            lz;
        logic [3:0]      vis;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        logic       ft;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic       dpn0;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];

    function automatic vec_t mk(
        input logic [19:0]     b,
        input logic [3:0]      dp,
        input logic [3:0]      en,
        input logic            lz,
        input logic [3:0]      vis,
        input logic [3:0][6:0] seg,
        input logic [3:0]      dpn
    );
        vec_t v;
        v.bin = b;
        v.dp  = dp;
        v.en  = en;
        v.lz  = lz;
        v.vis = vis;
        v.seg = seg;
        v.dpn = dpn;
        return v;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        big_bin  = v.bin;
        dp_in    = v.dp;
        digit_en = v.en;
        lz_en    = v.lz;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " AN"}, 32'(an_a), 32'hF);
        chk({tag, " seg"}, 32'(seg_a), 32'h7F);
        chk({tag, " dp_n"}, 32'(dpn_a), 32'h1);
        chk({tag, " ft"}, 32'(ft_a), 32'h0);
        chk({tag, " AN0"}, 32'(an_b), 32'hF);
        chk({tag, " seg0"}, 32'(seg_b), 32'h7F);
        chk({tag, " dp_n0"}, 32'(dpn_b), 32'h1);
        chk({tag, " ft0"}, 32'(ft_b), 32'h0);
    endtask

    // Counts cycles up to the next frame_tick, bounded.
    task automatic wait_ft(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ft_a && n < 40);
        chk("ft_seen", 32'(ft_a), 32'h1);
    endtask

    // Called in a frame_tick cycle; checks the 32 cycles that follow.
    task automatic run_frame(
        input vec_t        v,
        input int          chg_k,
        input logic [19:0] chg_bin
    );
        exp_t e;
        for (int k = 1; k <= 32; k++) begin
            int p, s;
            p = (k - 1) % 8;
            s = (k - 1) / 8;
            e.an   = 4'hF;
            e.seg  = 7'h7F;
            e.dpn  = 1'b1;
            e.ft   = (k == 32);
            e.an0  = 4'hF;
            e.seg0 = 7'h7F;
            e.dpn0 = 1'b1;
            if (v.vis[s]) begin
                e.an0  = ~(4'b0001 << s);
                e.seg0 = v.seg[s];
                e.dpn0 = v.dpn[s];
                if (p >= 2) begin
                    e.an  = e.an0;
                    e.seg = e.seg0;
                    e.dpn = e.dpn0;
                end
            end
            sb.push_back(e);
        end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("AN k=%0d", k), 32'(an_a), 32'(e.an));
            chk($sformatf("seg k=%0d", k), 32'(seg_a), 32'(e.seg));
            chk($sformatf("dp_n k=%0d", k), 32'(dpn_a), 32'(e.dpn));
            chk($sformatf("ft k=%0d", k), 32'(ft_a), 32'(e.ft));
            chk($sformatf("AN0 k=%0d", k), 32'(an_b), 32'(e.an0));
            chk($sformatf("seg0 k=%0d", k), 32'(seg_b), 32'(e.seg0));
            chk($sformatf("dp_n0 k=%0d", k), 32'(dpn_b), 32'(e.dpn0));
            chk($sformatf("ft0 k=%0d", k), 32'(ft_b), 32'(e.ft));
            if (k == chg_k) begin
                big_bin = chg_bin;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = mk({5'd4, 5'd3, 5'd2, 5'd1}, 4'h0, 4'hF, 1'b0, 4'hF,
                     {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF);
        vecs[1] = mk({5'd0, 5'd0, 5'd7, 5'd0}, 4'h0, 4'hF, 1'b1, 4'h3,
                     {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);
        vecs[2] = mk({5'd0, 5'd0, 5'd0, 5'd0}, 4'h0, 4'hF, 1'b1, 4'h1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
        vecs[3] = mk({5'd9, 5'd8, 5'd5, 5'd6}, 4'h1, 4'hB, 1'b0, 4'hB,
                     {7'h10, 7'h7F, 7'h12, 7'h02}, 4'hE);
        vecs[4] = mk({5'd0, 5'd2, 5'd0, 5'd1}, 4'h0, 4'hB, 1'b1, 4'h3,
                     {7'h7F, 7'h7F, 7'h40, 7'h79}, 4'hF);
        vecs[5] = mk({5'd15, 5'd10, 5'd0, 5'd0}, 4'hA, 4'hF, 1'b1, 4'hF,
                     {7'h0E, 7'h08, 7'h40, 7'h40}, 4'h5);
        vecs[6] = mk({5'd0, 5'd0, 5'd0, 5'd0}, 4'h0, 4'hF, 1'b0, 4'hF,
                     {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
        vecs[7] = mk({5'd14, 5'd13, 5'd12, 5'd11}, 4'h0, 4'hF, 1'b0, 4'hF,
                     {7'h06, 7'h21, 7'h46, 7'h03}, 4'hF);
        vecs[8] = mk({5'd9, 5'd8, 5'd7, 5'd6}, 4'h0, 4'hF, 1'b0, 4'hF,
                     {7'h10, 7'h00, 7'h78, 7'h02}, 4'hF);

        rst      = 1'b1;
        big_bin  = '0;
        dp_in    = '0;
        digit_en = '0;
        lz_en    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        wait_ft(n);
        chk("first_frame_len", 32'(n), 32'd32);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            wait_ft(n);
            chk($sformatf("frame_len v%0d", i), 32'(n), 32'd32);
            run_frame(vecs[i], 0, '0);
        end

        apply(vecs[0]);
        wait_ft(n);
        run_frame(vecs[0], 18, vecs[8].bin);
        run_frame(vecs[8], 0, '0);

        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midreset");
        repeat (2) @(negedge clk);
        chk_reset("midreset_hold");
        rst = 1'b0;
        apply(vecs[3]);
        wait_ft(n);
        chk("restart_frame_len", 32'(n), 32'd32);
        run_frame(vecs[3], 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
